peridot_pfc_arbiter: RTL

PERIDOT_PFC_ARBITER -- requirements
Module: peridot_pfc_arbiter

---
 rtl/peridot_pfc_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/peridot_pfc_arbiter.sv
// Two-port Avalon-MM front end sharing one PFC register command bus.
// Each transaction runs IDLE -> CMD -> ACK; a new winner is picked only in IDLE.
module peridot_pfc_arbiter #(
   parameter int FIXED_PRIORITY = 0
) (
   input  logic        csi_clk,
   input  logic        rsi_reset,
   input  logic [3:0]  avs_a_address,
   input  logic        avs_a_read,
   input  logic        avs_a_write,
   input  logic [31:0] avs_a_writedata,
   output logic [31:0] avs_a_readdata,
   output logic        avs_a_waitrequest,
   input  logic [3:0]  avs_b_address,
   input  logic        avs_b_read,
   input  logic        avs_b_write,
   input  logic [31:0] avs_b_writedata,
   output logic [31:0] avs_b_readdata,
   output logic        avs_b_waitrequest,
   output logic [36:0] coe_pfc_cmd,
   input  logic [31:0] coe_pfc_resp
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   state_t      state_r;
   state_t      state_s;
   logic        req_a_s;
   logic        req_b_s;
   logic        winner_s;
   logic        win_wr_s;
   logic [3:0]  win_addr_s;
   logic [31:0] win_data_s;
   logic        latch_s;
   logic        capture_s;
   logic        cmd_wr_s;
   logic        wait_a_s;
   logic        wait_b_s;

   logic        last_grant_r;
   logic        cmd_wr_r;
   logic [3:0]  cmd_addr_r;
   logic [31:0] cmd_data_r;
   logic [31:0] rdata_a_r;
   logic [31:0] rdata_b_r;
   logic        wait_a_r;
   logic        wait_b_r;

   assign req_a_s = avs_a_read | avs_a_write;
   assign req_b_s = avs_b_read | avs_b_write;

   // Winner selection; last_grant_r doubles as the granted port of the live transaction.
   always_comb begin
      winner_s = PORT_A;
      if (req_a_s && req_b_s) begin
         if (FIXED_PRIORITY != 0) begin
            winner_s = PORT_A;
         end else begin
            winner_s = (last_grant_r == PORT_A) ? PORT_B : PORT_A;
         end
      end else if (req_b_s) begin
         winner_s = PORT_B;
      end else begin
         winner_s = PORT_A;
      end
   end

   // Mux the winning port's transaction; read+write together counts as a write.
   always_comb begin
      if (winner_s == PORT_B) begin
         win_wr_s   = avs_b_write;
         win_addr_s = avs_b_address;
         win_data_s = avs_b_writedata;
      end else begin
         win_wr_s   = avs_a_write;
         win_addr_s = avs_a_address;
         win_data_s = avs_a_writedata;
      end
   end

   // State register.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_a_s || req_b_s) begin
               state_s = ST_CMD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CMD:  state_s = ST_ACK;
         ST_ACK:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Output decode: next values for the registered outputs.
   always_comb begin
      latch_s   = 1'b0;
      capture_s = 1'b0;
      cmd_wr_s  = 1'b0;
      wait_a_s  = 1'b1;
      wait_b_s  = 1'b1;
      case (state_r)
         ST_IDLE: begin
            if (req_a_s || req_b_s) begin
               latch_s  = 1'b1;
               cmd_wr_s = win_wr_s;
            end else begin
               latch_s  = 1'b0;
            end
         end
         ST_CMD: begin
            capture_s = ~cmd_wr_r;
            if (last_grant_r == PORT_B) begin
               wait_b_s = 1'b0;
            end else begin
               wait_a_s = 1'b0;
            end
         end
         ST_ACK:  latch_s = 1'b0;
         default: latch_s = 1'b0;
      endcase
   end

   // Transaction latch, write strobe, readdata capture and waitrequest registers.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         last_grant_r <= PORT_B;
         cmd_wr_r     <= 1'b0;
         cmd_addr_r   <= 4'h0;
         cmd_data_r   <= 32'h0;
         rdata_a_r    <= 32'h0;
         rdata_b_r    <= 32'h0;
         wait_a_r     <= 1'b1;
         wait_b_r     <= 1'b1;
      end else begin
         cmd_wr_r <= cmd_wr_s;
         wait_a_r <= wait_a_s;
         wait_b_r <= wait_b_s;
         if (latch_s) begin
            last_grant_r <= winner_s;
            cmd_addr_r   <= win_addr_s;
            cmd_data_r   <= win_data_s;
         end
         if (capture_s) begin
            if (last_grant_r == PORT_B) begin
               rdata_b_r <= coe_pfc_resp;
            end else begin
               rdata_a_r <= coe_pfc_resp;
            end
         end
      end
   end

   assign coe_pfc_cmd       = {cmd_wr_r, cmd_addr_r, cmd_data_r};
   assign avs_a_readdata    = rdata_a_r;
   assign avs_b_readdata    = rdata_b_r;
   assign avs_a_waitrequest = wait_a_r;
   assign avs_b_waitrequest = wait_b_r;

endmodule
